// File: rtl/bus_bridge_if.sv
// CPU data-bus bundle between the single-cycle CPU and the bus bridge.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic [31:0] Bus_rdata;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;

  // CPU side drives address/write, receives read data
  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  // Bridge side decodes address/write, returns read data
  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/bus_bridge.sv
// Address decoder between CPU data bus, data RAM and memory-mapped peripherals
// (7-seg display, LEDs, switches, cycle timer). Reads are same-cycle.
module bus_bridge #(
  parameter int unsigned DRAM_AW  = 14,
  parameter int unsigned SCAN_DIV = 20000,
  parameter int unsigned SW_W     = 24
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_addr,
  input  logic [31:0]        dram_rdata,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [SW_W-1:0]    sw,
  output logic [SW_W-1:0]    led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [31:0] ADDR_SEG   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;

  logic             periph;
  logic             sel_seg;
  logic             sel_timer;
  logic             sel_led;
  logic             sel_sw;
  logic [31:0]      seg_val;
  logic [31:0]      timer;
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic             scan_wrap;

  // Active-low 7-seg pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex7seg = 7'h40;
      4'h1: hex7seg = 7'h79;
      4'h2: hex7seg = 7'h24;
      4'h3: hex7seg = 7'h30;
      4'h4: hex7seg = 7'h19;
      4'h5: hex7seg = 7'h12;
      4'h6: hex7seg = 7'h02;
      4'h7: hex7seg = 7'h78;
      4'h8: hex7seg = 7'h00;
      4'h9: hex7seg = 7'h10;
      4'hA: hex7seg = 7'h08;
      4'hB: hex7seg = 7'h03;
      4'hC: hex7seg = 7'h46;
      4'hD: hex7seg = 7'h21;
      4'hE: hex7seg = 7'h06;
      default: hex7seg = 7'h0E;
    endcase
  endfunction

  // Address decode; any 0xFFFFFxxx address is kept away from DRAM
  always_comb begin
    periph    = (bus.Bus_addr[31:12] == 20'hFFFFF);
    sel_seg   = (bus.Bus_addr == ADDR_SEG);
    sel_timer = (bus.Bus_addr == ADDR_TIMER);
    sel_led   = (bus.Bus_addr == ADDR_LED);
    sel_sw    = (bus.Bus_addr == ADDR_SW);
    dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
    dram_wdata = bus.Bus_wdata;
    dram_wen   = bus.Bus_wen & ~periph & ~cpu_rst;
  end

  // Same-cycle read mux; peripherals return their pre-edge value
  always_comb begin
    bus.Bus_rdata = dram_rdata;
    if (periph) begin
      bus.Bus_rdata = 32'h0;
      if (sel_seg)   bus.Bus_rdata = seg_val;
      if (sel_timer) bus.Bus_rdata = timer;
      if (sel_led)   bus.Bus_rdata = 32'(led);
      if (sel_sw)    bus.Bus_rdata = 32'(sw_sync);
    end
  end

  // Writable peripheral registers; a timer write overrides that edge's increment
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      seg_val <= 32'h0;
      led     <= '0;
      timer   <= 32'h0;
    end else begin
      if (bus.Bus_wen && sel_seg) seg_val <= bus.Bus_wdata;
      if (bus.Bus_wen && sel_led) led     <= bus.Bus_wdata[SW_W-1:0];
      if (bus.Bus_wen && sel_timer) timer <= bus.Bus_wdata;
      else                          timer <= timer + 32'd1;
    end
  end

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Scan timing: digit advances once per SCAN_DIV cycles
  always_comb begin
    scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    idx_nxt   = idx + 3'd1;
  end

  // Digit scan; enable and segments reload together so they never skew
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
      dig_en   <= 8'hFE;
      dig_seg  <= 8'hC0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx_nxt;
      dig_en   <= ~(8'b1 << idx_nxt);
      dig_seg  <= {1'b1, hex7seg(4'(seg_val >> {idx_nxt, 2'b00}))};
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: decode, peripherals, sync, timer wrap, scan.
module tb_bus_bridge;

  localparam int unsigned DRAM_AW  = 14;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned SW_W     = 24;

  logic               cpu_clk;
  logic               cpu_rst;
  logic [DRAM_AW-1:0] dram_addr;
  logic [31:0]        dram_rdata;
  logic               dram_wen;
  logic [31:0]        dram_wdata;
  logic [SW_W-1:0]    sw;
  logic [SW_W-1:0]    led;
  logic [7:0]         dig_en;
  logic [7:0]         dig_seg;

  int vec_cnt;
  int err_cnt;

  bus_bridge_if bus_if ();

  bus_bridge #(
    .DRAM_AW  (DRAM_AW),
    .SCAN_DIV (SCAN_DIV),
    .SW_W     (SW_W)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .bus        (bus_if),
    .dram_addr  (dram_addr),
    .dram_rdata (dram_rdata),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .sw         (sw),
    .led        (led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  // 10 ns clock
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Count one comparison and report it if it misses
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns past it
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Drive one bus access
  task automatic drive(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
    bus_if.Bus_addr  = addr;
    bus_if.Bus_wen   = wen;
    bus_if.Bus_wdata = wdata;
    #1;
  endtask

  initial begin
    logic [2:0] exp_idx;
    logic [7:0] exp_en;
    vec_cnt    = 0;
    err_cnt    = 0;
    cpu_rst    = 1'b1;
    sw         = '0;
    dram_rdata = 32'h0;
    // Try a DRAM write while held in reset: must be blocked
    drive(32'h0000_0040, 1'b1, 32'hCAFE_F00D);
    check_eq("dram_wen_in_rst", 32'(dram_wen), 32'h0);
    step(); step(); step();
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_dig_en", 32'(dig_en), 32'hFE);
    check_eq("rst_dig_seg", 32'(dig_seg), 32'hC0);
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    check_eq("rst_timer", bus_if.Bus_rdata, 32'h0);

    // Release reset and write SEG=0xF on the first edge; then follow the scan
    cpu_rst = 1'b0;
    drive(32'hFFFF_F000, 1'b1, 32'h0000_000F);
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k == 1) drive(32'hFFFF_F000, 1'b0, 32'h0);
      exp_idx = 3'((k / 4) % 8);
      exp_en  = 8'hFF;
      exp_en[exp_idx] = 1'b0;
      check_eq($sformatf("scan_en_k%0d", k), 32'(dig_en), 32'(exp_en));
      if (k >= 32 && exp_idx == 3'd0)
        check_eq($sformatf("scan_seg_k%0d", k), 32'(dig_seg), 32'h8E);
      else
        check_eq($sformatf("scan_seg_k%0d", k), 32'(dig_seg), 32'hC0);
    end
    check_eq("seg_read", bus_if.Bus_rdata, 32'h0000_000F);

    // LED write: no DRAM strobe, readback next cycle
    drive(32'hFFFF_F060, 1'b1, 32'h00AB_CDEF);
    check_eq("led_no_dram_wen", 32'(dram_wen), 32'h0);
    step();
    check_eq("led_out", 32'(led), 32'h00AB_CDEF);
    drive(32'hFFFF_F060, 1'b0, 32'h0);
    check_eq("led_read", bus_if.Bus_rdata, 32'h00AB_CDEF);

    // DRAM write and same-cycle DRAM read
    drive(32'h0000_0010, 1'b1, 32'h1234_5678);
    check_eq("dram_wen", 32'(dram_wen), 32'h1);
    check_eq("dram_addr", 32'(dram_addr), 32'h4);
    check_eq("dram_wdata", dram_wdata, 32'h1234_5678);
    step();
    dram_rdata = 32'hDEAD_BEEF;
    drive(32'h0000_0010, 1'b0, 32'h0);
    check_eq("dram_read", bus_if.Bus_rdata, 32'hDEAD_BEEF);

    // Unmapped peripheral hole: reads 0, no DRAM strobe on write
    drive(32'hFFFF_F100, 1'b1, 32'h5555_5555);
    check_eq("hole_read", bus_if.Bus_rdata, 32'h0);
    check_eq("hole_no_dram_wen", 32'(dram_wen), 32'h0);
    step();
    // Writes to SW are ignored and LED is untouched by the hole write
    drive(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    check_eq("sw_write_ignored", bus_if.Bus_rdata, 32'h0);
    check_eq("led_kept", 32'(led), 32'h00AB_CDEF);

    // Switch synchroniser: two edges of latency
    sw = 24'h5A5A5A;
    #1;
    check_eq("sw_pre_n", bus_if.Bus_rdata, 32'h0);
    step();
    check_eq("sw_after_n", bus_if.Bus_rdata, 32'h0);
    step();
    check_eq("sw_after_n1", bus_if.Bus_rdata, 32'h005A_5A5A);

    // Timer load, wrap, and load overriding the increment
    drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
    step();
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    check_eq("timer_load", bus_if.Bus_rdata, 32'hFFFF_FFFE);
    step();
    check_eq("timer_max", bus_if.Bus_rdata, 32'hFFFF_FFFF);
    step();
    check_eq("timer_wrap", bus_if.Bus_rdata, 32'h0);
    drive(32'hFFFF_F020, 1'b1, 32'h0000_0100);
    step();
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    check_eq("timer_load100", bus_if.Bus_rdata, 32'h0000_0100);
    step();
    check_eq("timer_inc101", bus_if.Bus_rdata, 32'h0000_0101);

    // Reset mid-operation: writes lost, state back to reset values
    cpu_rst = 1'b1;
    drive(32'hFFFF_F060, 1'b1, 32'h0000_0055);
    step();
    check_eq("mid_rst_led", 32'(led), 32'h0);
    check_eq("mid_rst_dig_en", 32'(dig_en), 32'hFE);
    check_eq("mid_rst_dig_seg", 32'(dig_seg), 32'hC0);
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    check_eq("mid_rst_sw", bus_if.Bus_rdata, 32'h0);
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    check_eq("mid_rst_timer", bus_if.Bus_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
